// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts CUT responses into a MISR while the controller
// runs the test, then compares signature and vector count against golden values.
module bist_response_analyzer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = WIDTH'(8'h1D),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(8'h00),
    parameter logic [WIDTH-1:0] GOLDEN    = WIDTH'(8'h00),
    parameter int               N_VECTORS = 16,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             running,
    input  logic             bist_end,
    input  logic [WIDTH-1:0] resp,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_count,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_seq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_pass;
    logic             r_err;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sig_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic             w_err_nxt;

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] r);
        misr_next = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ r;
    endfunction

    // Saturating: a runaway test must not wrap back into a passing count.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_sig_nxt   = r_sig;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (running) begin
                    w_sig_nxt   = misr_next(SEED, resp);
                    w_cnt_nxt   = CNT_W'(1);
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_COMPACT;
                end else if (bist_end && r_state == S_IDLE) begin
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b0;
                    w_state_nxt = S_DONE;
                end
                // An end pulse without a test in progress is a protocol error.
                if (bist_end && !(r_state == S_IDLE && running))
                    w_err_nxt = 1'b1;
            end
            S_COMPACT: begin
                if (running) begin
                    w_sig_nxt = misr_next(r_sig, resp);
                    w_cnt_nxt = w_cnt_inc;
                end
                if (bist_end)
                    w_state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                w_done_nxt  = 1'b1;
                w_pass_nxt  = (r_sig == GOLDEN) && (r_cnt == CNT_W'(N_VECTORS));
                w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sig   <= w_sig_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign signature = r_sig;
    assign vec_count = r_cnt;
    assign busy      = (r_state == S_COMPACT) || (r_state == S_COMPARE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_seq   = r_err;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed bench for bist_response_analyzer: three parameterisations share one
// stimulus stream (defaults, GOLDEN=1D/N=9, and a 4-bit saturating counter).
module tb_bist_response_analyzer;

    logic       clk = 1'b0;
    logic       reset;
    logic       running;
    logic       bist_end;
    logic [7:0] resp;

    logic [7:0]  d_sig,  g_sig,  s_sig;
    logic [15:0] d_cnt,  g_cnt;
    logic [3:0]  s_cnt;
    logic        d_busy, g_busy, s_busy;
    logic        d_done, g_done, s_done;
    logic        d_pass, g_pass, s_pass;
    logic        d_err,  g_err,  s_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bist_response_analyzer u_def (
        .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .resp(resp),
        .signature(d_sig), .vec_count(d_cnt), .busy(d_busy), .done(d_done),
        .pass(d_pass), .err_seq(d_err)
    );

    bist_response_analyzer #(.GOLDEN(8'h1D), .N_VECTORS(9)) u_g1d (
        .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .resp(resp),
        .signature(g_sig), .vec_count(g_cnt), .busy(g_busy), .done(g_done),
        .pass(g_pass), .err_seq(g_err)
    );

    bist_response_analyzer #(.CNT_W(4), .N_VECTORS(15)) u_sat (
        .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .resp(resp),
        .signature(s_sig), .vec_count(s_cnt), .busy(s_busy), .done(s_done),
        .pass(s_pass), .err_seq(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic cyc(input logic run, input logic be, input logic [7:0] r);
        running  = run;
        bist_end = be;
        resp     = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        reset = 1'b1;
    endtask

    task automatic end_test();
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    logic [7:0] seq [9];

    initial begin
        seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h04; seq[3] = 8'h08; seq[4] = 8'h10;
        seq[5] = 8'h20; seq[6] = 8'h40; seq[7] = 8'h80; seq[8] = 8'h1D;
        running = 1'b0; bist_end = 1'b0; resp = 8'h00; reset = 1'b1;
        do_reset();

        chk("rst_sig",  {24'h0, d_sig}, 32'h00);
        chk("rst_cnt",  {16'h0, d_cnt}, 32'h0);
        chk("rst_busy", {31'h0, d_busy}, 32'h0);
        chk("rst_done", {31'h0, d_done}, 32'h0);
        chk("rst_pass", {31'h0, d_pass}, 32'h0);
        chk("rst_err",  {31'h0, d_err},  32'h0);

        // Clean pass with defaults; 4-bit counter saturates at 15.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'h00);
            if (i == 14) chk("sat_cnt15", {28'h0, s_cnt}, 32'hF);
        end
        chk("sat_hold", {28'h0, s_cnt}, 32'hF);
        chk("t1_busy_run", {31'h0, d_busy}, 32'h1);
        cyc(1'b0, 1'b1, 8'h00);
        chk("t1_busy_cmp", {31'h0, d_busy}, 32'h1);
        chk("t1_done_early", {31'h0, d_done}, 32'h0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("t1_sig",  {24'h0, d_sig}, 32'h00);
        chk("t1_cnt",  {16'h0, d_cnt}, 32'd16);
        chk("t1_done", {31'h0, d_done}, 32'h1);
        chk("t1_pass", {31'h0, d_pass}, 32'h1);
        chk("t1_busy_done", {31'h0, d_busy}, 32'h0);
        chk("t1_g_pass", {31'h0, g_pass}, 32'h0);
        chk("sat_pass", {31'h0, s_pass}, 32'h1);

        // Signature arithmetic, restarting from DONE.
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b0, (i == 0) ? 8'h01 : 8'h00);
            chk($sformatf("t2_sig%0d", i), {24'h0, g_sig}, {24'h0, seq[i]});
            if (i == 0) chk("t2_done_clr", {31'h0, g_done}, 32'h0);
        end
        end_test();
        chk("t2_cnt",  {16'h0, g_cnt}, 32'd9);
        chk("t2_done", {31'h0, g_done}, 32'h1);
        chk("t2_pass", {31'h0, g_pass}, 32'h1);
        chk("t2_d_pass", {31'h0, d_pass}, 32'h0);

        // Same stimulus with a 3-cycle pause after vector 4.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, (i == 0) ? 8'h01 : 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'hFF);
            chk("t3_pause_sig", {24'h0, g_sig}, 32'h08);
            chk("t3_pause_cnt", {16'h0, g_cnt}, 32'd4);
        end
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h00);
        end_test();
        chk("t3_sig",  {24'h0, g_sig}, 32'h1D);
        chk("t3_pass", {31'h0, g_pass}, 32'h1);

        // End pulse while in DONE: error flagged, verdict untouched.
        chk("t3_err_pre", {31'h0, g_err}, 32'h0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("dn_err",  {31'h0, g_err},  32'h1);
        chk("dn_done", {31'h0, g_done}, 32'h1);
        chk("dn_pass", {31'h0, g_pass}, 32'h1);
        chk("dn_busy", {31'h0, g_busy}, 32'h0);

        // Tenth vector breaks the count check.
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, (i == 0) ? 8'h01 : 8'h00);
        end_test();
        chk("t4_sig",  {24'h0, g_sig}, 32'h3A);
        chk("t4_cnt",  {16'h0, g_cnt}, 32'd10);
        chk("t4_done", {31'h0, g_done}, 32'h1);
        chk("t4_pass", {31'h0, g_pass}, 32'h0);

        // Protocol error from IDLE, then a normal test keeps err_seq.
        do_reset();
        chk("pe_err_rst", {31'h0, g_err}, 32'h0);
        cyc(1'b0, 1'b1, 8'h00);
        chk("pe_err",  {31'h0, g_err},  32'h1);
        chk("pe_done", {31'h0, g_done}, 32'h1);
        chk("pe_pass", {31'h0, g_pass}, 32'h0);
        chk("pe_busy", {31'h0, g_busy}, 32'h0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, (i == 0) ? 8'h01 : 8'h00);
        end_test();
        chk("pe2_pass", {31'h0, g_pass}, 32'h1);
        chk("pe2_err",  {31'h0, g_err},  32'h1);

        // Reset in the middle of a test, while running is still high.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, (i == 0) ? 8'h01 : 8'h00);
        chk("mr_sig_pre", {24'h0, g_sig}, 32'h10);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 8'h55);
        reset = 1'b1;
        chk("mr_sig",  {24'h0, g_sig}, 32'h00);
        chk("mr_cnt",  {16'h0, g_cnt}, 32'd0);
        chk("mr_busy", {31'h0, g_busy}, 32'h0);
        chk("mr_done", {31'h0, g_done}, 32'h0);
        chk("mr_err",  {31'h0, g_err},  32'h0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("mr_idle_sig", {24'h0, g_sig}, 32'h00);
        cyc(1'b0, 1'b1, 8'h00);
        chk("mr_pe_err",  {31'h0, g_err},  32'h1);
        chk("mr_pe_done", {31'h0, g_done}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
